// File: rtl/rx_block_writer.sv
// Writes DDC I/Q samples into the ping-pong sample RAM and stretches the ADC clip flag.
// Optional RX_TEST_PATTERN_EN replaces the samples with a ramp / inverted-ramp pattern.
module rx_block_writer #(
    parameter int SAMPLES_PER_BLOCK = 82,
    parameter int IQ_WIDTH          = 24,
    parameter int CLIP_HOLD         = 2400000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_on,
    input  logic [7:0]            rx_rate,
    input  logic                  iq_valid,
    input  logic [IQ_WIDTH-1:0]   iq_i,
    input  logic [IQ_WIDTH-1:0]   iq_q,
    input  logic                  adc_ovf,
    output logic                  mem_we,
    output logic [7:0]            mem_wr_addr,
    output logic [2*IQ_WIDTH-1:0] mem_wr_data,
    output logic                  adc_mem_block,
    output logic                  clip
);

    localparam int CW = $clog2(CLIP_HOLD + 1);
    localparam logic [CW-1:0] HOLD = CW'(CLIP_HOLD);
    localparam logic [6:0] LAST = 7'(SAMPLES_PER_BLOCK - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic half_q, half_d;
    logic blk_q, blk_d;
    logic we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [2*IQ_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0] clip_cnt_q, clip_cnt_d;
    logic clip_q, clip_d;

    logic rx_on_m_q, rx_on_s_q;
    logic [7:0] rate_m_q, rate_s_q, rate_prev_q;
    logic flush;
    logic [2*IQ_WIDTH-1:0] sample;

`ifdef RX_TEST_PATTERN_EN
    logic [IQ_WIDTH-1:0] ramp_q, ramp_d;

    assign sample = {ramp_q, ~ramp_q};

    always_comb begin
        ramp_d = ramp_q;
        if (we_d) ramp_d = ramp_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ramp_q <= '0;
        else        ramp_q <= ramp_d;
    end
`else
    assign sample = {iq_i, iq_q};
`endif

    // Both controls cross from the USB domain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_on_m_q   <= 1'b0;
            rx_on_s_q   <= 1'b0;
            rate_m_q    <= '0;
            rate_s_q    <= '0;
            rate_prev_q <= '0;
        end else begin
            rx_on_m_q   <= rx_on;
            rx_on_s_q   <= rx_on_m_q;
            rate_m_q    <= rx_rate;
            rate_s_q    <= rate_m_q;
            rate_prev_q <= rate_s_q;
        end
    end

    assign flush = !rx_on_s_q || (rate_s_q != rate_prev_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        half_d  = half_q;
        blk_d   = blk_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (rx_on_s_q) state_d = FILL;
            end
            FILL: begin
                if (flush) begin
                    // Partial half is abandoned and overwritten later
                    idx_d = '0;
                    if (!rx_on_s_q) state_d = IDLE;
                end else if (iq_valid) begin
                    we_d   = 1'b1;
                    addr_d = {half_q, idx_q};
                    data_d = sample;
                    if (idx_q == LAST) begin
                        idx_d  = '0;
                        half_d = ~half_q;
                        blk_d  = half_q;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (adc_ovf)               clip_cnt_d = HOLD;
        else if (clip_cnt_q != '0) clip_cnt_d = clip_cnt_q - 1'b1;
        clip_d = adc_ovf || (clip_cnt_q > CW'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            half_q     <= 1'b1;
            blk_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            clip_cnt_q <= '0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            half_q     <= half_d;
            blk_q      <= blk_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clip_cnt_q <= clip_cnt_d;
            clip_q     <= clip_d;
        end
    end

    assign mem_we        = we_q;
    assign mem_wr_addr   = addr_q;
    assign mem_wr_data   = data_q;
    assign adc_mem_block = blk_q;
    assign clip          = clip_q;

endmodule
